seq_divider: RTL and testbench

//  Sequential restoring divider: the inverse operation to the ripple add/sub datapath, iterating one

---
 rtl/seq_divider.sv | 128 ++++++++++++
 tb/tb_seq_divider.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one trial-subtract/restore step per clock; DIV_SIGNED_EN selects two's-complement operands.
// Latency: WIDTH edges from accepted start to done_out (WIDTH+1 with DIV_SIGNED_EN for the sign-fixup cycle).
// Backpressure: start_in ignored while busy_out, no queueing; a start in the done_out cycle is accepted.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             div_by_zero_out
);
  localparam int CW = $clog2(WIDTH) + 1;

`ifdef DIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE, CALC, NEG, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, q, dvs;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_nxt, q_nxt;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             accept, last;

`ifdef DIV_SIGNED_EN
  logic dvd_neg, q_neg;
  assign dvd_mag = dividend_in[WIDTH-1] ? -dividend_in : dividend_in;
  assign dvs_mag = divisor_in[WIDTH-1]  ? -divisor_in  : divisor_in;
`else
  assign dvd_mag = dividend_in;
  assign dvs_mag = divisor_in;
`endif

  assign accept = start_in && (state == IDLE || state == DONE);
  assign last   = (state == CALC) && (count == CW'(WIDTH - 1));

  // q holds the unconsumed dividend bits at the top and the quotient bits growing from the bottom
  assign shifted = {rem, q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};
  assign rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_nxt   = {q[WIDTH-2:0], ~trial[WIDTH]};

`ifdef DIV_SIGNED_EN
  assign busy_out = (state == CALC) || (state == NEG);
`else
  assign busy_out = (state == CALC);
`endif
  assign done_out = (state == DONE);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start_in ? CALC : IDLE;
      CALC: begin
        if (last) begin
`ifdef DIV_SIGNED_EN
          state_nxt = NEG;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      NEG: state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rem             <= '0;
      q               <= '0;
      dvs             <= '0;
      count           <= '0;
      quotient_out    <= '0;
      remainder_out   <= '0;
      div_by_zero_out <= 1'b0;
`ifdef DIV_SIGNED_EN
      dvd_neg         <= 1'b0;
      q_neg           <= 1'b0;
`endif
    end else if (accept) begin
      rem   <= '0;
      q     <= dvd_mag;
      dvs   <= dvs_mag;
      count <= '0;
`ifdef DIV_SIGNED_EN
      dvd_neg <= dividend_in[WIDTH-1];
      q_neg   <= dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1];
`endif
    end else if (state == CALC) begin
      rem   <= rem_nxt;
      q     <= q_nxt;
      count <= count + CW'(1);
`ifndef DIV_SIGNED_EN
      if (last) begin
        quotient_out    <= q_nxt;
        remainder_out   <= rem_nxt;
        div_by_zero_out <= (dvs == '0);
      end
`endif
    end
`ifdef DIV_SIGNED_EN
    // Zero divisor keeps the all-ones quotient; negating |dividend| restores the dividend itself
    else if (state == NEG) begin
      quotient_out    <= (dvs == '0) ? '1 : (q_neg ? -q : q);
      remainder_out   <= dvd_neg ? -rem : rem;
      div_by_zero_out <= (dvs == '0);
    end
`endif
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=4); expectations switch with DIV_SIGNED_EN.
module tb_seq_divider;
  localparam int WIDTH = 4;
`ifdef DIV_SIGNED_EN
  localparam bit SGN = 1'b1;
  localparam int LAT = WIDTH + 1;
`else
  localparam bit SGN = 1'b0;
  localparam int LAT = WIDTH;
`endif

  logic             clk_in;
  logic             rst_in;
  logic             start_in;
  logic [WIDTH-1:0] dividend_in;
  logic [WIDTH-1:0] divisor_in;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] quotient_out;
  logic [WIDTH-1:0] remainder_out;
  logic             div_by_zero_out;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .start_in(start_in),
    .dividend_in(dividend_in),
    .divisor_in(divisor_in),
    .busy_out(busy_out),
    .done_out(done_out),
    .quotient_out(quotient_out),
    .remainder_out(remainder_out),
    .div_by_zero_out(div_by_zero_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, then scramble operands to prove they were captured
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start_in = 1'b1; dividend_in = a; divisor_in = b;
    tick();
    start_in = 1'b0;
    dividend_in = WIDTH'($urandom);
    divisor_in  = WIDTH'($urandom);
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done_out !== 1'b1 && n < 3 * LAT) begin
      tick();
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er, input logic ez);
    int n;
    start_op(a, b);
    wait_done(0, n);
    check({tag, "_lat"}, n, LAT);
    check({tag, "_q"}, quotient_out, eq);
    check({tag, "_r"}, remainder_out, er);
    check({tag, "_dz"}, div_by_zero_out, ez);
    check({tag, "_busy"}, busy_out, 1'b0);
    tick();
    check({tag, "_pulse"}, done_out, 1'b0);
  endtask

  initial begin
    int n;
    rst_in = 1'b1; start_in = 1'b0; dividend_in = '0; divisor_in = '0;
    tick();
    tick();
    rst_in = 1'b0;
    check("rst_busy", busy_out, 1'b0);
    check("rst_done", done_out, 1'b0);
    check("rst_q", quotient_out, 4'h0);
    check("rst_r", remainder_out, 4'h0);
    check("rst_dz", div_by_zero_out, 1'b0);

    // basic unsigned patterns (signed build reads 13 as -3, 15 as -1)
    run("u13_3", 4'd13, 4'd3, SGN ? 4'hF : 4'd4, SGN ? 4'h0 : 4'd1, 1'b0);
    run("u15_1", 4'd15, 4'd1, SGN ? 4'hF : 4'd15, 4'h0, 1'b0);

    run("z7_0", 4'd7, 4'd0, 4'hF, 4'd7, 1'b1);
    run("z6_2", 4'd6, 4'd2, 4'd3, 4'd0, 1'b0);

    // busy protection: second start two edges in must be ignored
    start_in = 1'b1; dividend_in = 4'd9; divisor_in = 4'd2;
    tick();
    start_in = 1'b0;
    tick();
    start_in = 1'b1; dividend_in = 4'd5; divisor_in = 4'd5;
    tick();
    start_in = 1'b0;
    check("busy_mid", busy_out, 1'b1);
    wait_done(2, n);
    check("busy_lat", n, LAT);
    check("busy_q", quotient_out, SGN ? 4'hD : 4'd4);
    check("busy_r", remainder_out, SGN ? 4'hF : 4'd1);
    n = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      if (done_out === 1'b1) n++;
    end
    check("busy_single_done", n, 0);

    // reset on the second CALC edge abandons the division
    start_op(4'd14, 4'd3);
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("mid_rst_busy", busy_out, 1'b0);
    check("mid_rst_done", done_out, 1'b0);
    check("mid_rst_q", quotient_out, 4'h0);
    check("mid_rst_r", remainder_out, 4'h0);
    check("mid_rst_dz", div_by_zero_out, 1'b0);
    n = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      if (done_out === 1'b1) n++;
    end
    check("mid_rst_no_done", n, 0);
    run("fresh14_3", 4'd14, 4'd3, SGN ? 4'h0 : 4'd4, SGN ? 4'hE : 4'd2, 1'b0);

    // back-to-back: start held through the busy period and re-used in the DONE cycle
    start_in = 1'b1; dividend_in = 4'd12; divisor_in = 4'd5;
    tick();
    wait_done(0, n);
    check("b2b_lat1", n, LAT);
    check("b2b_q1", quotient_out, SGN ? 4'h0 : 4'd2);
    check("b2b_r1", remainder_out, SGN ? 4'hC : 4'd2);
    dividend_in = 4'd3; divisor_in = 4'd7;
    tick();
    start_in = 1'b0;
    check("b2b_busy", busy_out, 1'b1);
    check("b2b_done_low", done_out, 1'b0);
    check("b2b_q_held", quotient_out, SGN ? 4'h0 : 4'd2);
    wait_done(0, n);
    check("b2b_lat2", n, LAT);
    check("b2b_q2", quotient_out, 4'd0);
    check("b2b_r2", remainder_out, 4'd3);

`ifdef DIV_SIGNED_EN
    run("s_m7_2", 4'b1001, 4'd2, 4'b1101, 4'b1111, 1'b0);
    run("s_7_m2", 4'd7, 4'b1110, 4'b1101, 4'd1, 1'b0);
    run("s_m8_m1", 4'b1000, 4'b1111, 4'b1000, 4'd0, 1'b0);
    run("s_m3_0", 4'b1101, 4'd0, 4'hF, 4'b1101, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
